// File: rtl/bm_sfifo_wr_arb.sv
// bm_sfifo_wr_arb: two-requester write arbiter in front of one shared synchronous FIFO.
// Latency: a request seen in IDLE gets its first ack one cycle later. Owner handover costs no idle cycle.
// Backpressure: fifo_full stalls the current owner. Ownership and the burst count are frozen until the FIFO drains.
//
// Ports:
//   clock, reset_n      single clock; asynchronous active-low reset
//   req_a/data_a/ack_a  requester A. ack_a is high in the cycle A's word is written.
//   req_b/data_b/ack_b  requester B. ack_b is high in the cycle B's word is written.
//   fifo_full           full flag from the shared FIFO
//   fifo_write_n        active-low FIFO write strobe
//   fifo_data           FIFO write data: the owner's data, or zero when idle
//   busy                high while some requester owns the FIFO
//   cnt_a, cnt_b        saturating 8-bit write counters. They exist only when SFIFO_ARB_STATS_EN is defined.
//
// Build option: define SFIFO_ARB_STATS_EN to add the cnt_a/cnt_b statistics outputs.
module bm_sfifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4   // legal range 1..15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  input  logic             fifo_full,
  output logic             fifo_write_n,
  output logic [WIDTH-1:0] fifo_data,
  output logic             busy
`ifdef SFIFO_ARB_STATS_EN
  ,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  // The last_owner encoding. It is reset to B so that A wins the first tie.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // The burst ends on the ack that is taken while the count holds this value.
  localparam logic [3:0] LP_BURST_LAST = 4'(BURST_MAX - 1);

  state_t     r_state;
  logic [3:0] r_burst_cnt;
  logic       r_last_owner;

  state_t     w_next_state;
  logic [3:0] w_next_cnt;
  logic       w_next_last;
  logic       w_burst_end;

  // The acks depend only on state and live inputs. Reset drives the state to IDLE
  // asynchronously, so both acks fall in the same cycle that reset is asserted.
  assign ack_a        = (r_state == ST_OWN_A) && req_a && !fifo_full;
  assign ack_b        = (r_state == ST_OWN_B) && req_b && !fifo_full;
  assign fifo_write_n = !(ack_a || ack_b);
  assign busy         = (r_state != ST_IDLE);
  assign w_burst_end  = (r_burst_cnt == LP_BURST_LAST);

  always_comb begin
    fifo_data = '0;
    case (r_state)
      ST_OWN_A: fifo_data = data_a;
      ST_OWN_B: fifo_data = data_b;
      default:  fifo_data = '0;
    endcase
  end

  // Next-state logic.
  // When the FIFO is full and the owner keeps its request high, no branch below changes
  // anything. Ownership and the count therefore hold for as long as the stall lasts.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_burst_cnt;
    w_next_last  = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = '0;
        if (req_a && req_b) begin
          w_next_state = (r_last_owner == OWNER_B) ? ST_OWN_A : ST_OWN_B;
        end else if (req_a) begin
          w_next_state = ST_OWN_A;
        end else if (req_b) begin
          w_next_state = ST_OWN_B;
        end
      end

      ST_OWN_A: begin
        if (!req_a) begin
          // The owner has withdrawn. Hand over directly if B is waiting.
          w_next_cnt   = '0;
          w_next_last  = OWNER_A;
          w_next_state = req_b ? ST_OWN_B : ST_IDLE;
        end else if (ack_a) begin
          if (w_burst_end) begin
            w_next_cnt = '0;
            if (req_b) begin
              w_next_state = ST_OWN_B;
              w_next_last  = OWNER_A;
            end
            // With B idle, A keeps the FIFO and starts a fresh burst.
          end else begin
            w_next_cnt = r_burst_cnt + 4'd1;
          end
        end
      end

      ST_OWN_B: begin
        if (!req_b) begin
          w_next_cnt   = '0;
          w_next_last  = OWNER_B;
          w_next_state = req_a ? ST_OWN_A : ST_IDLE;
        end else if (ack_b) begin
          if (w_burst_end) begin
            w_next_cnt = '0;
            if (req_a) begin
              w_next_state = ST_OWN_A;
              w_next_last  = OWNER_B;
            end
          end else begin
            w_next_cnt = r_burst_cnt + 4'd1;
          end
        end
      end

      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_burst_cnt  <= '0;
      r_last_owner <= OWNER_B;
    end else begin
      r_state      <= w_next_state;
      r_burst_cnt  <= w_next_cnt;
      r_last_owner <= w_next_last;
    end
  end

`ifdef SFIFO_ARB_STATS_EN
  logic [7:0] r_cnt_a;
  logic [7:0] r_cnt_b;

  // Each counter saturates at 255 and never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (ack_a && (r_cnt_a != 8'hFF)) r_cnt_a <= r_cnt_a + 8'd1;
      if (ack_b && (r_cnt_b != 8'hFF)) r_cnt_b <= r_cnt_b + 8'd1;
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;
`endif

endmodule

// File: tb/tb_bm_sfifo_wr_arb.sv
// Bench for bm_sfifo_wr_arb. It drives directed per-cycle steps and queues the expected
// outputs as each step is driven. Each queued entry is popped and compared at mid-cycle.
module tb_bm_sfifo_wr_arb;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0, fifo_full = 1'b0;
  logic [W-1:0] data_a = '0, data_b = '0;
  logic         ack_a, ack_b, fifo_write_n, busy;
  logic [W-1:0] fifo_data;
`ifdef SFIFO_ARB_STATS_EN
  logic [7:0]   cnt_a, cnt_b;
`endif

  bm_sfifo_wr_arb #(.WIDTH(W), .BURST_MAX(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .fifo_full(fifo_full), .fifo_write_n(fifo_write_n),
    .fifo_data(fifo_data), .busy(busy)
`ifdef SFIFO_ARB_STATS_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         aa;
    logic         ab;
    logic         wn;
    logic         bz;
    logic [W-1:0] dat;
  } exp_t;

  localparam logic [1:0] OI = 2'd0, OA = 2'd1, OB = 2'd2;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic push_exp(input logic ea, input logic eb, input logic [1:0] own, input string tag);
    exp_t e;
    e.aa  = ea;
    e.ab  = eb;
    e.wn  = ~(ea | eb);
    e.bz  = (own != OI);
    e.dat = (own == OA) ? data_a : (own == OB) ? data_b : '0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_chk();
    exp_t  e, o;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {ack_a, ack_b, fifo_write_n, busy, fifo_data};
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed={ack_a,ack_b,wr_n,busy,data}=%b%b%b%b_%h expected=%b%b%b%b_%h",
               t, o.aa, o.ab, o.wn, o.bz, o.dat, e.aa, e.ab, e.wn, e.bz, e.dat);
      end
    end
  endtask

  // One normal cycle with reset released. The inputs are driven 1 time unit after the
  // rising edge, and the outputs are checked 4 units later.
  task automatic cyc(input logic ra, input logic rb, input logic full,
                     input logic ea, input logic eb, input logic [1:0] own, input string tag);
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    req_a     = ra;
    req_b     = rb;
    fifo_full = full;
    data_a    = 8'($urandom);
    data_b    = 8'($urandom);
    push_exp(ea, eb, own, tag);
    #4;
    pop_chk();
  endtask

  // One cycle with reset asserted mid-cycle. The outputs must be in their reset state by the check point.
  task automatic rst_cyc(input logic ra, input logic rb, input string tag);
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    req_a     = ra;
    req_b     = rb;
    fifo_full = 1'b0;
    data_a    = 8'($urandom);
    data_b    = 8'($urandom);
    push_exp(1'b0, 1'b0, OI, tag);
    #4;
    pop_chk();
  endtask

  initial begin
    // Reset state, with requests already pending
    rst_cyc(1, 1, "reset_outputs");

    // A alone and steady: one IDLE cycle, then A acks every cycle with no gap at a burst boundary
    rst_cyc(1, 0, "t1_reset");
    cyc(1, 0, 0, 0, 0, OI, "t1_idle");
    for (int i = 1; i <= 9; i++) cyc(1, 0, 0, 1, 0, OA, $sformatf("t1_a%0d", i));
    cyc(0, 0, 0, 0, 0, OA, "t1_drop_own_a");
    cyc(0, 0, 0, 0, 0, OI, "t1_back_idle");

    // Both steady: A x4, B x4, A x4
    rst_cyc(1, 1, "t2_reset");
    cyc(1, 1, 0, 0, 0, OI, "t2_idle");
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, OA, $sformatf("t2_a%0d", i));
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1, OB, $sformatf("t2_b%0d", i));
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, OA, $sformatf("t2_a2_%0d", i));

    // FIFO full for 3 cycles after A's second write: the stall holds ownership and the burst count
    rst_cyc(1, 1, "t3_reset");
    cyc(1, 1, 0, 0, 0, OI, "t3_idle");
    cyc(1, 1, 0, 1, 0, OA, "t3_a0");
    cyc(1, 1, 0, 1, 0, OA, "t3_a1");
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, OA, $sformatf("t3_stall%0d", i));
    cyc(1, 1, 0, 1, 0, OA, "t3_a2");
    cyc(1, 1, 0, 1, 0, OA, "t3_a3");
    cyc(1, 1, 0, 0, 1, OB, "t3_b0");
    cyc(1, 1, 0, 0, 1, OB, "t3_b1");
    cyc(1, 1, 1, 0, 0, OB, "t3_b_stall");
    cyc(1, 1, 0, 0, 1, OB, "t3_b2");

    // A drops after one write while B waits: direct handover, then a fresh 4-word B burst
    rst_cyc(1, 1, "t4_reset");
    cyc(1, 1, 0, 0, 0, OI, "t4_idle");
    cyc(1, 1, 0, 1, 0, OA, "t4_a0");
    cyc(0, 1, 0, 0, 0, OA, "t4_a_drop");
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1, OB, $sformatf("t4_b%0d", i));
    cyc(1, 1, 0, 1, 0, OA, "t4_a_after_b");

    // last_owner becomes A when A leaves to IDLE, so B wins the next tie
    rst_cyc(1, 0, "t4b_reset");
    cyc(1, 0, 0, 0, 0, OI, "t4b_idle");
    cyc(1, 0, 0, 1, 0, OA, "t4b_a0");
    cyc(0, 0, 0, 0, 0, OA, "t4b_a_drop");
    cyc(1, 1, 0, 0, 0, OI, "t4b_idle2");
    cyc(1, 1, 0, 0, 1, OB, "t4b_b_wins_tie");

    // Reset in the middle of a B burst: outputs clear at once, and A is served first afterwards
    rst_cyc(0, 1, "t5_reset");
    cyc(0, 1, 0, 0, 0, OI, "t5_idle");
    cyc(0, 1, 0, 0, 1, OB, "t5_b0");
    cyc(1, 1, 0, 0, 1, OB, "t5_b1");
    rst_cyc(1, 1, "t5_reset_mid_burst");
    cyc(1, 1, 0, 0, 0, OI, "t5_idle2");
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, OA, $sformatf("t5_a%0d", i));
    cyc(1, 1, 0, 0, 1, OB, "t5_b_after");

    // FIFO full while idle: ownership is still granted, but no write happens
    rst_cyc(0, 1, "t6_reset");
    cyc(0, 1, 1, 0, 0, OI, "t6_idle_full");
    cyc(0, 1, 1, 0, 0, OB, "t6_own_b_full");
    cyc(0, 1, 0, 0, 1, OB, "t6_b0");

`ifdef SFIFO_ARB_STATS_EN
    // The statistics counters saturate at 255
    rst_cyc(1, 0, "t7_reset");
    checks++;
    assert (cnt_a === 8'd0 && cnt_b === 8'd0) else begin
      errors++;
      $error("FAIL t7_cnt_reset observed=%0d/%0d expected=0/0", cnt_a, cnt_b);
    end
    cyc(1, 0, 0, 0, 0, OI, "t7_idle");
    for (int i = 1; i < 300; i++) cyc(1, 0, 0, 1, 0, OA, $sformatf("t7_a%0d", i));
    checks++;
    assert (cnt_a === 8'd255) else begin
      errors++;
      $error("FAIL t7_cnt_a observed=%0d expected=255", cnt_a);
    end
    checks++;
    assert (cnt_b === 8'd0) else begin
      errors++;
      $error("FAIL t7_cnt_b observed=%0d expected=0", cnt_b);
    end
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d entries expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bm_sfifo_wr_arb.md
BM_SFIFO_WR_ARB -- requirements
Module: bm_sfifo_wr_arb

Interface
REQ-001 Parameter WIDTH, default 8, data word width (matches FIFO data width).
REQ-002 Parameter BURST_MAX, default 4, max consecutive writes per grant; legal range 1..15.
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset_n  input  1  asynchronous reset, active-low.
REQ-005 req_a  input  1  requester A has a word to write (active high).
REQ-006 data_a  input  WIDTH  requester A write data.
REQ-007 ack_a  output  1  A's word is written at this clock edge.
REQ-008 req_b  input  1  requester B has a word to write (active high).
REQ-009 data_b  input  WIDTH  requester B write data.
REQ-010 ack_b  output  1  B's word is written at this clock edge.
REQ-011 fifo_full  input  1  full flag from the shared synchronous FIFO.
REQ-012 fifo_write_n  output  1  FIFO write strobe (active low).
REQ-013 fifo_data  output  WIDTH  FIFO write data.
REQ-014 busy  output  1  high when state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, OWN_A, OWN_B; registered state; no writes occur in IDLE.
REQ-016 IDLE: only one req high -> that owner next cycle; both high -> owner is the requester other than last_owner; none -> stay IDLE.
REQ-017 ack_x SHALL be combinational: (state==OWN_x) & req_x & ~fifo_full; ack_a and ack_b never both high.
REQ-018 fifo_write_n SHALL be ~(ack_a | ack_b); fifo_full high -> fifo_write_n high, no exception.
REQ-019 fifo_data SHALL be data_a in OWN_A, data_b in OWN_B, all-zeros in IDLE.
REQ-020 burst_cnt (4 bits) SHALL increment on each ack in an OWN state; it is held on full-stall cycles.
REQ-021 Burst end: ack with burst_cnt==BURST_MAX-1 -> other requesting: switch to other owner; else own req high: stay, burst_cnt=0; else IDLE.
REQ-022 Owner req low in OWN state -> other requesting: switch to other owner; else IDLE; burst_cnt=0.
REQ-023 Switching owners SHALL take no idle cycle; next owner may ack in the cycle immediately following.
REQ-024 last_owner SHALL update to the owner being left whenever leaving an OWN state.
REQ-025 Full-stall in OWN state with req held SHALL keep ownership indefinitely; no rotation while stalled.
REQ-026 Latency: req from IDLE -> first ack in second cycle (one cycle in IDLE).

Reset
REQ-027 reset_n low SHALL immediately force state=IDLE, burst_cnt=0, last_owner=B (A wins first tie), stats counters=0.
REQ-028 During reset: ack_a=0, ack_b=0, fifo_write_n=1, fifo_data=0, busy=0; a burst interrupted by reset is not resumed.

Configuration
REQ-029 Macro SFIFO_ARB_STATS_EN defined: add outputs cnt_a, cnt_b (8 bits each), counting ack_a/ack_b, saturating at 255.
REQ-030 Macro undefined: cnt_a/cnt_b ports and counters absent; all other behaviour identical.

Verification
REQ-031 Reset; req_a=1 steady, req_b=0, fifo_full=0 -> cycle 0 IDLE, ack_a=1 every cycle from cycle 1, no gap at burst boundary.
REQ-032 req_a=req_b=1 steady -> ack pattern A,A,A,A,B,B,B,B,A... after initial IDLE cycle; fifo_data follows owner.
REQ-033 Both requesting; fifo_full=1 for 3 cycles after A's 2nd write -> fifo_write_n=1 for 3 cycles, then 2 more A writes, then B.
REQ-034 A drops req after 1 write, B requesting -> next cycle OWN_B, ack_b=1; last_owner=A.
REQ-035 reset_n low mid-burst of B -> outputs reset same cycle; after release with both requesting, A served first.
REQ-036 SFIFO_ARB_STATS_EN, req_a steady 300 cycles -> cnt_a=255 held, cnt_b=0.
